// File: rtl/frodo_agu_pkg.sv
// rtl/frodo_agu_pkg.sv - shared types and constants for the Frodo MAC address-generation unit
//
// Contents:
//   ELEM_W      element width inside a packed memory word
//   TAG_LANE_W  width of the A-lane select carried with each beat
//   TAG_ADDR_W  width of the destination word address carried with each beat
//   state_t     sequencer state (IDLE, RUN, DRAIN)
//   tag_t       per-beat side information travelling alongside the read data
package frodo_agu_pkg;

    localparam int ELEM_W     = 16;
    localparam int TAG_LANE_W = 2;
    localparam int TAG_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  acc_init;
        logic                  acc_last;
        logic [TAG_LANE_W-1:0] a_lane;
        logic [TAG_ADDR_W-1:0] d_addr;
    } tag_t;

endpackage

// File: rtl/agu_tag_pipe.sv
// rtl/agu_tag_pipe.sv - fixed-depth valid+data delay line that never stalls
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   in_valid    beat present at the input this cycle
//   in_data     side information for that beat (zeroed internally when invalid)
//   out_valid   beat emerging DEPTH cycles later
//   out_data    its side information (zero when out_valid=0)
//   any_valid   some stage still holds a beat; used to decide the pipe has drained
module agu_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d    = '0;
        data_d     = '0;
        valid_d[0] = in_valid;
        // Bubbles carry zero data so downstream flag outputs read 0 between beats.
        data_d[0]  = in_valid ? in_data : '0;
        for (int s = 1; s < DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/frodo_mac_agu.sv
// rtl/frodo_mac_agu.sv - loop sequencer and address generator for D = A*B (+C) on packed words
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start                          one-cycle pulse; latches config when idle
//   cfg_m, cfg_k, cfg_jw           rows of A, inner dimension, output word-columns
//   cfg_add_c                      seed accumulators from C (1) or zero (0)
//   base_a/b/c/d                   word base addresses of the four matrices
//   step_en                        issue permission; 0 inserts a bubble
//   rd_en_*, rd_addr_*             registered operand read strobes/addresses
//   a_lane, acc_init, acc_last     beat side information aligned with read data
//   mac_data                       packed MAC results, lane 0 in LSBs
//   wr_en, wr_addr, wr_data        registered result write
//   busy, done                     job running; one-cycle completion pulse
module frodo_mac_agu
    import frodo_agu_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ADDR_W  = 12,
    parameter int DIM_W   = 10,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [DIM_W-1:0]          cfg_m,
    input  logic [DIM_W-1:0]          cfg_k,
    input  logic [DIM_W-1:0]          cfg_jw,
    input  logic                      cfg_add_c,
    input  logic [ADDR_W-1:0]         base_a,
    input  logic [ADDR_W-1:0]         base_b,
    input  logic [ADDR_W-1:0]         base_c,
    input  logic [ADDR_W-1:0]         base_d,
    input  logic                      step_en,
    output logic                      rd_en_a,
    output logic                      rd_en_b,
    output logic                      rd_en_c,
    output logic [ADDR_W-1:0]         rd_addr_a,
    output logic [ADDR_W-1:0]         rd_addr_b,
    output logic [ADDR_W-1:0]         rd_addr_c,
    output logic [$clog2(LANES)-1:0]  a_lane,
    output logic                      acc_init,
    output logic                      acc_last,
    input  logic [LANES*ELEM_W-1:0]   mac_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*ELEM_W-1:0]   wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int LANE_W = $clog2(LANES);
    localparam int TAG_W  = $bits(tag_t);

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [DIM_W-1:0]          m_q, m_d, k_q, k_d, jw_q, jw_d;
    logic                      add_c_q, add_c_d;
    logic [ADDR_W-1:0]         base_a_q, base_a_d, base_b_q, base_b_d;
    logic [ADDR_W-1:0]         base_c_q, base_c_d, base_d_q, base_d_d;

    logic [DIM_W-1:0]          k_idx_q, k_idx_d, jw_idx_q, jw_idx_d, i_idx_q, i_idx_d;
    logic [ADDR_W-1:0]         out_idx_q, out_idx_d;   // i*jw_cfg + jw
    logic [ADDR_W-1:0]         a_row_q, a_row_d;       // i*ceil(k_cfg/LANES)
    logic [ADDR_W-1:0]         b_off_q, b_off_d;       // k*jw_cfg + jw
    logic [ADDR_W-1:0]         b_col_q, b_col_d;       // jw

    logic                      rd_en_a_q, rd_en_a_d, rd_en_b_q, rd_en_b_d, rd_en_c_q, rd_en_c_d;
    logic [ADDR_W-1:0]         rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic [ADDR_W-1:0]         rd_addr_c_q, rd_addr_c_d;
    tag_t                      tag_q, tag_d;

    logic                      wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [LANES*ELEM_W-1:0]   wr_data_q, wr_data_d;

    // Effective config: the start cycle already issues the first beat, so it
    // must see the live inputs; afterwards the latched copy is used.
    logic                      idle;
    logic [DIM_W-1:0]          eff_m, eff_k, eff_jw;
    logic                      eff_add_c;
    logic [ADDR_W-1:0]         eff_base_a, eff_base_b, eff_base_c, eff_base_d;
    logic                      zero_dim, launch, issue;
    logic                      last_k, last_jw, last_i;
    logic [DIM_W:0]            k_round;
    logic [ADDR_W-1:0]         k_words;

    tag_t                      rd_tag;
    logic                      rd_valid, rd_any;
    logic                      mac_valid, mac_any;
    logic [ADDR_W-1:0]         mac_addr;

    always_comb begin
        idle       = (state_q == IDLE);
        eff_m      = idle ? cfg_m     : m_q;
        eff_k      = idle ? cfg_k     : k_q;
        eff_jw     = idle ? cfg_jw    : jw_q;
        eff_add_c  = idle ? cfg_add_c : add_c_q;
        eff_base_a = idle ? base_a    : base_a_q;
        eff_base_b = idle ? base_b    : base_b_q;
        eff_base_c = idle ? base_c    : base_c_q;
        eff_base_d = idle ? base_d    : base_d_q;

        zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_jw == '0);
        launch   = idle && start && !zero_dim;
        issue    = step_en && (launch || (state_q == RUN));

        last_k   = (k_idx_q  == eff_k  - DIM_W'(1));
        last_jw  = (jw_idx_q == eff_jw - DIM_W'(1));
        last_i   = (i_idx_q  == eff_m  - DIM_W'(1));

        // Words per row of A, rounded up.
        k_round  = {1'b0, eff_k} + (DIM_W+1)'(LANES - 1);
        k_words  = ADDR_W'(k_round >> LANE_W);

        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        m_d         = m_q;
        k_d         = k_q;
        jw_d        = jw_q;
        add_c_d     = add_c_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        base_c_d    = base_c_q;
        base_d_d    = base_d_q;
        k_idx_d     = k_idx_q;
        jw_idx_d    = jw_idx_q;
        i_idx_d     = i_idx_q;
        out_idx_d   = out_idx_q;
        a_row_d     = a_row_q;
        b_off_d     = b_off_q;
        b_col_d     = b_col_q;
        rd_en_a_d   = 1'b0;
        rd_en_b_d   = 1'b0;
        rd_en_c_d   = 1'b0;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        rd_addr_c_d = rd_addr_c_q;
        tag_d       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_dim) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        m_d      = cfg_m;
                        k_d      = cfg_k;
                        jw_d     = cfg_jw;
                        add_c_d  = cfg_add_c;
                        base_a_d = base_a;
                        base_b_d = base_b;
                        base_c_d = base_c;
                        base_d_d = base_d;
                    end
                end
            end
            RUN: begin
            end
            DRAIN: begin
                if (!rd_en_a_q && !rd_any && !mac_any) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (issue) begin
            rd_en_a_d   = 1'b1;
            rd_addr_a_d = eff_base_a + a_row_q + ADDR_W'(k_idx_q >> LANE_W);
            rd_en_b_d   = 1'b1;
            rd_addr_b_d = eff_base_b + b_off_q;
            if ((k_idx_q == '0) && eff_add_c) begin
                rd_en_c_d   = 1'b1;
                rd_addr_c_d = eff_base_c + out_idx_q;
            end
            tag_d.acc_init = (k_idx_q == '0);
            tag_d.acc_last = last_k;
            tag_d.a_lane   = k_idx_q[LANE_W-1:0];
            tag_d.d_addr   = eff_base_d + out_idx_q;

            // Advance k, then jw, then i; everything returns to zero after the
            // final beat so the next start sees clean counters.
            if (!last_k) begin
                k_idx_d = k_idx_q + DIM_W'(1);
                b_off_d = b_off_q + ADDR_W'(eff_jw);
            end else begin
                k_idx_d   = '0;
                out_idx_d = out_idx_q + ADDR_W'(1);
                if (!last_jw) begin
                    jw_idx_d = jw_idx_q + DIM_W'(1);
                    b_col_d  = b_col_q + ADDR_W'(1);
                    b_off_d  = b_col_q + ADDR_W'(1);
                end else begin
                    jw_idx_d = '0;
                    b_col_d  = '0;
                    b_off_d  = '0;
                    if (!last_i) begin
                        i_idx_d = i_idx_q + DIM_W'(1);
                        a_row_d = a_row_q + k_words;
                    end else begin
                        i_idx_d   = '0;
                        a_row_d   = '0;
                        out_idx_d = '0;
                        state_d   = DRAIN;
                    end
                end
            end
        end

        wr_en_d   = mac_valid;
        wr_addr_d = mac_valid ? mac_addr : wr_addr_q;
        wr_data_d = mac_valid ? mac_data : wr_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_q         <= '0;
            k_q         <= '0;
            jw_q        <= '0;
            add_c_q     <= 1'b0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            base_d_q    <= '0;
            k_idx_q     <= '0;
            jw_idx_q    <= '0;
            i_idx_q     <= '0;
            out_idx_q   <= '0;
            a_row_q     <= '0;
            b_off_q     <= '0;
            b_col_q     <= '0;
            rd_en_a_q   <= 1'b0;
            rd_en_b_q   <= 1'b0;
            rd_en_c_q   <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            rd_addr_c_q <= '0;
            tag_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            m_q         <= m_d;
            k_q         <= k_d;
            jw_q        <= jw_d;
            add_c_q     <= add_c_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_c_q    <= base_c_d;
            base_d_q    <= base_d_d;
            k_idx_q     <= k_idx_d;
            jw_idx_q    <= jw_idx_d;
            i_idx_q     <= i_idx_d;
            out_idx_q   <= out_idx_d;
            a_row_q     <= a_row_d;
            b_off_q     <= b_off_d;
            b_col_q     <= b_col_d;
            rd_en_a_q   <= rd_en_a_d;
            rd_en_b_q   <= rd_en_b_d;
            rd_en_c_q   <= rd_en_c_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            rd_addr_c_q <= rd_addr_c_d;
            tag_q       <= tag_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Memory read latency: tags line up with the returning operand words.
    agu_tag_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (TAG_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_en_a_q),
        .in_data   (tag_q),
        .out_valid (rd_valid),
        .out_data  (rd_tag),
        .any_valid (rd_any)
    );

    // MAC latency: only the last-k beat of an output needs to reach the write port.
    agu_tag_pipe #(
        .DEPTH (MAC_LAT),
        .WIDTH (ADDR_W)
    ) u_mac_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_valid && rd_tag.acc_last),
        .in_data   (rd_tag.d_addr),
        .out_valid (mac_valid),
        .out_data  (mac_addr),
        .any_valid (mac_any)
    );

    assign rd_en_a   = rd_en_a_q;
    assign rd_en_b   = rd_en_b_q;
    assign rd_en_c   = rd_en_c_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign rd_addr_c = rd_addr_c_q;
    assign a_lane    = rd_tag.a_lane;
    assign acc_init  = rd_tag.acc_init;
    assign acc_last  = rd_tag.acc_last;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_frodo_mac_agu.sv
// tb/tb_frodo_mac_agu.sv - randomized self-checking bench for frodo_mac_agu
module tb_frodo_mac_agu;

    localparam int LANES   = 4;
    localparam int ADDR_W  = 12;
    localparam int DIM_W   = 10;
    localparam int RD_LAT  = 1;
    localparam int MAC_LAT = 2;
    localparam int AMOD    = 1 << ADDR_W;
    localparam int MAXC    = 512;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [DIM_W-1:0]     cfg_m = '0, cfg_k = '0, cfg_jw = '0;
    logic                 cfg_add_c = 1'b0;
    logic [ADDR_W-1:0]    base_a = '0, base_b = '0, base_c = '0, base_d = '0;
    logic                 step_en = 1'b0;
    logic [63:0]          mac_data = '0;
    logic                 rd_en_a, rd_en_b, rd_en_c;
    logic [ADDR_W-1:0]    rd_addr_a, rd_addr_b, rd_addr_c;
    logic [1:0]           a_lane;
    logic                 acc_init, acc_last;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [63:0]          wr_data;
    logic                 busy, done;

    frodo_mac_agu #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_jw(cfg_jw), .cfg_add_c(cfg_add_c),
        .base_a(base_a), .base_b(base_b), .base_c(base_c), .base_d(base_d),
        .step_en(step_en),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_en_c(rd_en_c),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .a_lane(a_lane), .acc_init(acc_init), .acc_last(acc_last),
        .mac_data(mac_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int a;
        int b;
        int cen;
        int c;
        int cyc;
    } beat_t;

    typedef struct {
        int addr;
        int cyc;
    } wr_t;

    beat_t       exp_beats[$];
    wr_t         exp_wrs[$];
    bit          en_sched[MAXC];
    logic [63:0] mac_hist[MAXC];
    bit          exp_init[MAXC];
    bit          exp_last[MAXC];
    int          exp_lane[MAXC];
    bit          lane_v[MAXC];

    // Expected traffic from the matrix-walk rules; cycle 0 is the start cycle.
    task automatic build_model(input int m, input int k, input int jw, input int addc,
                               input int ba, input int bb, input int bc, input int bd,
                               output int done_cyc, output int n_beats);
        int t;
        int last_cyc;
        int kw;
        beat_t bt;
        wr_t   w;
        exp_beats.delete();
        exp_wrs.delete();
        for (int c = 0; c < MAXC; c++) begin
            exp_init[c] = 0;
            exp_last[c] = 0;
            exp_lane[c] = 0;
            lane_v[c]   = 0;
        end
        t = 0;
        last_cyc = 0;
        kw = (k + LANES - 1) / LANES;
        n_beats = m * k * jw;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < jw; j++) begin
                for (int kk = 0; kk < k; kk++) begin
                    while (t < MAXC - 16 && !en_sched[t]) t++;
                    bt.cyc = t + 1;
                    t++;
                    bt.a   = (ba + i * kw + kk / LANES) % AMOD;
                    bt.b   = (bb + kk * jw + j) % AMOD;
                    bt.cen = (kk == 0 && addc != 0) ? 1 : 0;
                    bt.c   = (bc + i * jw + j) % AMOD;
                    exp_beats.push_back(bt);
                    exp_init[bt.cyc + RD_LAT] = (kk == 0);
                    exp_last[bt.cyc + RD_LAT] = (kk == k - 1);
                    exp_lane[bt.cyc + RD_LAT] = kk % LANES;
                    lane_v[bt.cyc + RD_LAT]   = 1;
                    if (kk == k - 1) begin
                        w.addr = (bd + i * jw + j) % AMOD;
                        w.cyc  = bt.cyc + 1 + RD_LAT + MAC_LAT;
                        exp_wrs.push_back(w);
                    end
                    last_cyc = bt.cyc;
                end
            end
        end
        done_cyc = (n_beats == 0) ? 1 : last_cyc + RD_LAT + MAC_LAT + 2;
    endtask

    // stall_mode: 0 no stalls, 1 alternate 1/0, 2 random. poke re-pulses start mid-job.
    task automatic run_job(input int m, input int k, input int jw, input int addc,
                           input int ba, input int bb, input int bc, input int bd,
                           input int stall_mode, input bit poke);
        int done_cyc;
        int n_beats;
        bit exp_busy;
        beat_t bt;
        wr_t   w;
        for (int c = 0; c < MAXC; c++) begin
            case (stall_mode)
                0:       en_sched[c] = 1;
                1:       en_sched[c] = (c % 2 == 0);
                default: en_sched[c] = ($urandom_range(0, 2) != 0);
            endcase
        end
        en_sched[0] = 1;
        build_model(m, k, jw, addc, ba, bb, bc, bd, done_cyc, n_beats);

        @(negedge clk);
        cfg_m     = DIM_W'(m);
        cfg_k     = DIM_W'(k);
        cfg_jw    = DIM_W'(jw);
        cfg_add_c = addc[0];
        base_a    = ADDR_W'(ba);
        base_b    = ADDR_W'(bb);
        base_c    = ADDR_W'(bc);
        base_d    = ADDR_W'(bd);
        start     = 1'b1;
        step_en   = en_sched[0];
        mac_data  = {$urandom, $urandom};
        mac_hist[0] = mac_data;

        for (int t = 1; t <= done_cyc + 3; t++) begin
            @(negedge clk);
            exp_busy = (n_beats > 0) && (t < done_cyc);
            chk("busy", busy, exp_busy);
            chk("done", done, t == done_cyc);
            if (rd_en_a) begin
                if (exp_beats.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    bt = exp_beats.pop_front();
                    chk("beat_cycle", t, bt.cyc);
                    chk("rd_addr_a", rd_addr_a, bt.a);
                    chk("rd_en_b", rd_en_b, 1);
                    chk("rd_addr_b", rd_addr_b, bt.b);
                    chk("rd_en_c", rd_en_c, bt.cen);
                    if (bt.cen != 0) chk("rd_addr_c", rd_addr_c, bt.c);
                end
            end else begin
                chk("rd_en_b_idle", rd_en_b, 0);
                chk("rd_en_c_idle", rd_en_c, 0);
            end
            chk("acc_init", acc_init, exp_init[t]);
            chk("acc_last", acc_last, exp_last[t]);
            if (lane_v[t]) chk("a_lane", a_lane, exp_lane[t]);
            if (wr_en) begin
                if (exp_wrs.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    w = exp_wrs.pop_front();
                    chk("wr_cycle", t, w.cyc);
                    chk("wr_addr", wr_addr, w.addr);
                    chk("wr_data", wr_data, mac_hist[t-1]);
                end
            end
            start = 1'b0;
            if (poke && t == 2) begin
                start     = 1'b1;
                cfg_m     = DIM_W'($urandom_range(1, 5));
                cfg_k     = DIM_W'($urandom_range(1, 9));
                cfg_jw    = DIM_W'($urandom_range(1, 5));
                cfg_add_c = ~cfg_add_c;
                base_a    = ADDR_W'($urandom);
                base_b    = ADDR_W'($urandom);
                base_c    = ADDR_W'($urandom);
                base_d    = ADDR_W'($urandom);
            end
            step_en  = en_sched[t];
            mac_data = {$urandom, $urandom};
            mac_hist[t] = mac_data;
        end
        chk("beats_left", exp_beats.size(), 0);
        chk("writes_left", exp_wrs.size(), 0);
    endtask

    task automatic chk_all_zero(input string where);
        chk({where, "_rd_en_a"}, rd_en_a, 0);
        chk({where, "_rd_en_b"}, rd_en_b, 0);
        chk({where, "_rd_en_c"}, rd_en_c, 0);
        chk({where, "_rd_addr_a"}, rd_addr_a, 0);
        chk({where, "_rd_addr_b"}, rd_addr_b, 0);
        chk({where, "_rd_addr_c"}, rd_addr_c, 0);
        chk({where, "_a_lane"}, a_lane, 0);
        chk({where, "_acc_init"}, acc_init, 0);
        chk({where, "_acc_last"}, acc_last, 0);
        chk({where, "_wr_en"}, wr_en, 0);
        chk({where, "_wr_addr"}, wr_addr, 0);
        chk({where, "_wr_data"}, wr_data, 0);
        chk({where, "_busy"}, busy, 0);
        chk({where, "_done"}, done, 0);
    endtask

    initial begin
        int m, k, jw, addc;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;

        run_job(1, 4, 1, 1, 'h000, 'h100, 'h200, 'h300, 0, 0);
        run_job(2, 5, 2, 0, 'h010, 'h040, 'h080, 'h0C0, 0, 0);
        run_job(2, 5, 2, 0, 'h010, 'h040, 'h080, 'h0C0, 1, 0);
        run_job(3, 0, 2, 1, 'h001, 'h002, 'h003, 'h004, 0, 0);
        run_job(0, 3, 2, 1, 'h001, 'h002, 'h003, 'h004, 0, 0);
        run_job(2, 3, 0, 0, 'h001, 'h002, 'h003, 'h004, 0, 0);
        run_job(1, 4, 1, 0, 'h000, 'hFFE, 'h000, 'h000, 0, 0);
        run_job(2, 3, 2, 1, 'hFF0, 'h7FA, 'hFFE, 'hFFD, 0, 1);

        for (int r = 0; r < 8; r++) begin
            m    = $urandom_range(1, 3);
            k    = $urandom_range(1, 9);
            jw   = $urandom_range(1, 3);
            addc = $urandom_range(0, 1);
            run_job(m, k, jw, addc, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                    $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), 2, (r % 2) == 1);
        end

        // Reset in the middle of a running job.
        @(negedge clk);
        cfg_m = 2; cfg_k = 4; cfg_jw = 2; cfg_add_c = 1'b1;
        base_a = 'h123; base_b = 'h456; base_c = 'h789; base_d = 'hABC;
        start = 1'b1;
        step_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("wr_en_in_reset", wr_en, 0);
        end
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("wr_en_after_reset", wr_en, 0);
            chk("busy_after_reset", busy, 0);
        end

        run_job(2, 6, 2, 1, 'h200, 'h300, 'h400, 'h500, 0, 0);
        run_job(1, 7, 3, 0, 'hFFF, 'hFFC, 'h000, 'hFFE, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
